word_packer: RTL
================

# word_packer

Upstream stage of the buffered-handshake FIFO element. It accepts a narrow snooped stream (one IN_WIDTH lane per beat, with an end-of-packet flag) and packs consecutive beats into LANES-wide words. It presents each word on a valid/ready output that connects directly to the FIFO element's idata/idata_vld/idata_rdy. A packet end flushes a partial word, with the number of valid lanes reported alongside it.

## Interface
- IN_WIDTH, 8, width of one input lane
- LANES, 4, lanes per output word (≥2); output width OW = IN_WIDTH*LANES
- CNT_WIDTH, $clog2(LANES+1), width of obytes
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- idata  in  IN_WIDTH  input lane
- idata_vld  in  1  input beat valid
- idata_rdy  out  1  packer can accept a beat
- ilast  in  1  beat is last of packet; qualified by idata_vld
- odata  out  OW  packed word; lane i = bits [i*IN_WIDTH +: IN_WIDTH]; first beat in lane 0
- odata_vld  out  1  word valid
- odata_rdy  in  1  downstream accepts word
- obytes  out  CNT_WIDTH  valid lanes in odata, 1..LANES
- olast  out  1  word ends a packet

## Operation
- Beat transfer (shift_in) = idata_vld && idata_rdy. Word transfer (shift_out) = odata_vld && odata_rdy.
- Two register stages:
  - accumulator: acc data, acc_cnt 0..LANES-1, pend flag
  - output register: odata, obytes, olast, odata_vld
- Accumulator states:
  - FILLING (pend=0): each shift_in writes idata into lane acc_cnt.
  - A beat completes a word when acc_cnt==LANES-1 or ilast=1.
  - On the completing beat:
    - If out_free = !odata_vld || shift_out, the word (including this beat) loads straight into the output register. obytes = acc_cnt+1, olast = ilast. acc_cnt returns to 0.
    - Otherwise the word stays in the accumulator with pend=1 (state PENDING); the beat's lane, count and ilast are stored there.
  - PENDING: idata_rdy=0. When out_free, the pending word moves to the output register; pend=0 and acc_cnt=0 in that same cycle.
- idata_rdy = !pend. This is registered-only and does not depend combinationally on odata_rdy.
- Unused lanes of a partial word are 0. The accumulator clears after each word transfers, so stale data is never output.
- ilast together with a full word (acc_cnt==LANES-1) gives obytes=LANES and olast=1.
- Output register: odata_vld is set on load and cleared on shift_out with no load. Load and shift_out in the same cycle keep odata_vld=1 with the new word.
- odata/obytes/olast are held stable while odata_vld && !odata_rdy.
- Reset (at any time, including mid-packet or with a word pending): partial and pending words are discarded and all state returns to reset values.

## Timing
- Reset values: idata_rdy=1, odata=0, odata_vld=0, obytes=0, olast=0, acc_cnt=0, pend=0.
- Latency: completing beat accepted in cycle t → word on odata with odata_vld=1 in cycle t+1, provided out_free in t.
- Throughput: with odata_rdy held 1, every input beat is accepted, with no bubbles across word or packet boundaries.
- Backpressure: with odata_rdy=0, at most one word in the output register plus one pending word is held. idata_rdy drops the cycle after the pending word forms. It rises the cycle after out_free is seen in PENDING.
- All outputs come directly from flops.

## Structure
- No shared package. OW and CNT_WIDTH are localparams derived from the parameters.
- One natural sub-module: word_packer_oreg, the output register with its valid/ready logic, parameterised on OW and CNT_WIDTH.
- The accumulator/FSM stays in the top module.
- Intended pairing: odata/odata_vld/odata_rdy connect straight to the FIFO element's input. obytes and olast are concatenated into its data when it is built with DATA_WIDTH = OW+CNT_WIDTH+1.

## Test plan
- Full words: IN_WIDTH=8, LANES=4, odata_rdy=1; beats 0x11,0x22,0x33,0x44 (ilast on 0x44) → one word 0x44332211, obytes=4, olast=1, one cycle after the 4th beat; idata_rdy stays 1.
- Partial flush: beats 0xAA,0xBB with ilast on 0xBB → odata=0x0000BBAA, obytes=2, olast=1; the next packet starts in lane 0.
- Backpressure: odata_rdy=0, stream 8 beats 0x01..0x08 → first word 0x04030201 held stable; second word pends; idata_rdy=0 from the cycle after beat 8. Raise odata_rdy → both words delivered in order on consecutive cycles; idata_rdy returns to 1.
- Random valid/ready: random gaps on idata_vld and random odata_rdy over 1000 beats with random packet lengths → scoreboard matches lane order, obytes and olast; no word is dropped or duplicated.
- Reset mid-word: 3 beats accepted, then rst pulsed for 1 cycle → all outputs at reset values; the next 4 beats form a clean word with no residue from the discarded beats.
- Reset with a pending word: rst while pend=1 and odata_vld=1 → both words discarded; idata_rdy=1 and odata_vld=0 the cycle after reset.

Source files
------------

// File: rtl/word_packer_oreg.sv
// Output register of the packer: holds one packed word with its lane count and
// end-of-packet flag behind a valid/ready handshake.
module word_packer_oreg #(
    parameter int OW        = 32,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [OW-1:0]        data_i,
    input  logic [CNT_WIDTH-1:0] bytes_i,
    input  logic                 last_i,
    input  logic                 rdy_i,
    output logic [OW-1:0]        data_o,
    output logic [CNT_WIDTH-1:0] bytes_o,
    output logic                 last_o,
    output logic                 vld_o,
    output logic                 free_o
);

    logic [OW-1:0]        data_q,  data_d;
    logic [CNT_WIDTH-1:0] bytes_q, bytes_d;
    logic                 last_q,  last_d;
    logic                 vld_q,   vld_d;

    // A new word may enter when the register is empty or is being drained now.
    assign free_o = !vld_q || rdy_i;

    always_comb begin
        data_d  = data_q;
        bytes_d = bytes_q;
        last_d  = last_q;
        vld_d   = vld_q;
        if (load_i) begin
            data_d  = data_i;
            bytes_d = bytes_i;
            last_d  = last_i;
            vld_d   = 1'b1;
        end else if (vld_q && rdy_i) begin
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            bytes_q <= '0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            bytes_q <= bytes_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
        end
    end

    assign data_o  = data_q;
    assign bytes_o = bytes_q;
    assign last_o  = last_q;
    assign vld_o   = vld_q;

endmodule

// File: rtl/word_packer.sv
// Packs narrow input beats into LANES-wide words; a packet end flushes a
// partial word. One word can wait in the accumulator behind the output register.
module word_packer #(
    parameter int IN_WIDTH = 8,
    parameter int LANES    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IN_WIDTH-1:0]                  idata,
    input  logic                                 idata_vld,
    output logic                                 idata_rdy,
    input  logic                                 ilast,
    output logic [IN_WIDTH*LANES-1:0]            odata,
    output logic                                 odata_vld,
    input  logic                                 odata_rdy,
    output logic [$clog2(LANES+1)-1:0]           obytes,
    output logic                                 olast
);

    localparam int OW        = IN_WIDTH * LANES;
    localparam int CNT_WIDTH = $clog2(LANES + 1);

    typedef enum logic {FILLING = 1'b0, PENDING = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        acc_q,   acc_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 last_q,  last_d;
    logic                 rdy_q,   rdy_d;

    logic [OW-1:0]        acc_beat;
    logic [OW-1:0]        ld_data;
    logic [CNT_WIDTH-1:0] ld_bytes;
    logic                 ld_last;
    logic                 load;
    logic                 out_free;
    logic                 shift_in;
    logic                 complete;

    assign shift_in = idata_vld && rdy_q;
    assign complete = (cnt_q == CNT_WIDTH'(LANES - 1)) || ilast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILLING;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILLING: if (shift_in && complete && !out_free) state_d = PENDING;
            PENDING: if (out_free) state_d = FILLING;
            default: state_d = FILLING;
        endcase
    end

    // Accumulator update and the word offered to the output register.
    always_comb begin
        acc_beat = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CNT_WIDTH'(i)) acc_beat[i*IN_WIDTH +: IN_WIDTH] = idata;
        end
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        load     = 1'b0;
        ld_data  = acc_beat;
        ld_last  = ilast;
        ld_bytes = cnt_q + CNT_WIDTH'(1);
        case (state_q)
            FILLING: begin
                if (shift_in) begin
                    if (complete && out_free) begin
                        load  = 1'b1;
                        acc_d = '0;
                        cnt_d = '0;
                    end else if (complete) begin
                        acc_d  = acc_beat;
                        last_d = ilast;
                    end else begin
                        acc_d = acc_beat;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            PENDING: begin
                ld_data = acc_q;
                ld_last = last_q;
                if (out_free) begin
                    load  = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
        rdy_d = (state_d == FILLING);
    end

    word_packer_oreg #(
        .OW        (OW),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_oreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (ld_data),
        .bytes_i (ld_bytes),
        .last_i  (ld_last),
        .rdy_i   (odata_rdy),
        .data_o  (odata),
        .bytes_o (obytes),
        .last_o  (olast),
        .vld_o   (odata_vld),
        .free_o  (out_free)
    );

    assign idata_rdy = rdy_q;

endmodule
